// File: rtl/serv_fcsr_pkg.sv
// Shared select/op codes, FSM state type and field widths for the serial fcsr sequencer.
// Op encodings match the integer CSR source codes so both paths decode identically.
package serv_fcsr_pkg;

    localparam logic [1:0] SEL_RSVD   = 2'b00;
    localparam logic [1:0] SEL_FFLAGS = 2'b01;
    localparam logic [1:0] SEL_FRM    = 2'b10;
    localparam logic [1:0] SEL_FCSR   = 2'b11;

    localparam logic [1:0] OP_CSR = 2'b00;
    localparam logic [1:0] OP_EXT = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int FFLAGS_W = 5;
    localparam int FRM_W    = 3;
    localparam int FCSR_W   = FFLAGS_W + FRM_W;

    function automatic logic [3:0] field_width(input logic [1:0] sel);
        case (sel)
            SEL_FFLAGS: return 4'(FFLAGS_W);
            SEL_FRM:    return 4'(FRM_W);
            SEL_FCSR:   return 4'(FCSR_W);
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/serv_fcsr_flag_acc.sv
// fflags owner: merges FPU flag reports directly in IDLE, parks them in pend_r during ACCESS.
// Latency 1 cycle; never stalls the FPU, so no reported flag can be lost across a CSR access.
module serv_fcsr_flag_acc
    import serv_fcsr_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  state_t              state,
    input  logic                i_flags_valid,
    input  logic [FFLAGS_W-1:0] i_flags,
    input  logic                wr_en,
    input  logic [FFLAGS_W-1:0] wr_val,
    output logic [FFLAGS_W-1:0] fflags
);

    logic [FFLAGS_W-1:0] fflags_r;
    logic [FFLAGS_W-1:0] pend_r;
    logic [FFLAGS_W-1:0] strobe;

    assign strobe = i_flags_valid ? i_flags : '0;
    assign fflags = fflags_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fflags_r <= '0;
            pend_r   <= '0;
        end else begin
            case (state)
                IDLE:   fflags_r <= fflags_r | strobe;
                ACCESS: pend_r   <= pend_r | strobe;
                COMMIT: begin
                    // Flags raised while the CSR op was in flight survive even a clear.
                    fflags_r <= (wr_en ? wr_val : fflags_r) | pend_r | strobe;
                    pend_r   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/serv_fcsr_ctrl.sv
// Serial fcsr sequencer: W bits/cycle read-modify-write of fflags/frm/fcsr; accept->o_done = 32/W+1 cycles.
// Ready only in IDLE; requester holds valid. Optional FCSR_FRM_CHECK_EN flags reserved rounding modes.
module serv_fcsr_ctrl
    import serv_fcsr_pkg::*;
#(
    parameter int W = 1
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [1:0]          i_req_sel,
    input  logic [1:0]          i_req_op,
    input  logic [W-1:0]        i_d,
    output logic [W-1:0]        o_q,
    output logic                o_done,
    input  logic                i_flags_valid,
    input  logic [FFLAGS_W-1:0] i_flags,
    output logic [FFLAGS_W-1:0] o_fflags,
    output logic [FRM_W-1:0]    o_frm,
    output logic                o_frm_invalid
);

    localparam int SLICES = 32 / W;
    localparam int CW     = $clog2(SLICES);
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic [FCSR_W-1:0]   old_r;
    logic [FCSR_W-1:0]   new_r;
    logic [FCSR_W-1:0]   new_nxt;
    logic [FCSR_W-1:0]   snap;
    logic [1:0]          sel_r;
    logic [1:0]          op_r;
    logic [FRM_W-1:0]    frm_r;
    logic [FFLAGS_W-1:0] fflags;
    logic [3:0]          fw;
    logic [W-1:0]        q;
    logic                wr;
    logic                ff_wr;
    logic                frm_wr;
    int                  p;
    logic                ob;
    logic                nb;

    assign fw = field_width(sel_r);

    always_comb begin
        case (i_req_sel)
            SEL_FFLAGS: snap = FCSR_W'(fflags);
            SEL_FRM:    snap = FCSR_W'(frm_r);
            SEL_FCSR:   snap = {frm_r, fflags};
            default:    snap = '0;
        endcase
    end

    // Per-slice old bit out and modified bit in; positions past the field read 0 and are not stored.
    always_comb begin
        q       = '0;
        new_nxt = new_r;
        p       = 0;
        ob      = 1'b0;
        nb      = 1'b0;
        for (int i = 0; i < W; i++) begin
            p  = int'(cnt_r) * W + i;
            ob = (p < FCSR_W) ? old_r[p[2:0]] : 1'b0;
            case (op_r)
                OP_EXT:  nb = i_d[i];
                OP_SET:  nb = ob | i_d[i];
                OP_CLR:  nb = ob & ~i_d[i];
                default: nb = ob;
            endcase
            if (state_r == ACCESS) q[i] = ob;
            if (p < int'(fw)) new_nxt[p[2:0]] = nb;
        end
    end

    // Select bit 0 marks fflags as a target, bit 1 marks frm.
    assign wr     = (op_r != OP_CSR) && (sel_r != SEL_RSVD);
    assign ff_wr  = (state_r == COMMIT) && wr && sel_r[0];
    assign frm_wr = (state_r == COMMIT) && wr && sel_r[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            old_r   <= '0;
            new_r   <= '0;
            sel_r   <= SEL_RSVD;
            op_r    <= OP_CSR;
            frm_r   <= '0;
        end else begin
            case (state_r)
                IDLE: if (i_req_valid) begin
                    state_r <= ACCESS;
                    sel_r   <= i_req_sel;
                    op_r    <= i_req_op;
                    old_r   <= snap;
                    new_r   <= '0;
                    cnt_r   <= '0;
                end
                ACCESS: begin
                    new_r <= new_nxt;
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == LAST) state_r <= COMMIT;
                end
                COMMIT: begin
                    state_r <= IDLE;
                    if (frm_wr)
                        frm_r <= (sel_r == SEL_FCSR) ? new_r[FCSR_W-1:FFLAGS_W] : new_r[FRM_W-1:0];
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    serv_fcsr_flag_acc u_flag_acc (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .state         (state_r),
        .i_flags_valid (i_flags_valid),
        .i_flags       (i_flags),
        .wr_en         (ff_wr),
        .wr_val        (new_r[FFLAGS_W-1:0]),
        .fflags        (fflags)
    );

`ifdef FCSR_FRM_CHECK_EN
    logic frm_inv_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) frm_inv_r <= 1'b0;
        else       frm_inv_r <= (frm_r == 3'b101) || (frm_r == 3'b110) || (frm_r == 3'b111);
    end

    assign o_frm_invalid = frm_inv_r;
`else
    assign o_frm_invalid = 1'b0;
`endif

    assign o_req_ready = (state_r == IDLE);
    assign o_done      = (state_r == COMMIT);
    assign o_q         = q;
    assign o_fflags    = fflags;
    assign o_frm       = frm_r;

endmodule

// File: tb/tb_serv_fcsr_ctrl.sv
// Directed bench for serv_fcsr_ctrl: W=1 instance driven from a vector table, W=4 instance by hand.
module tb_serv_fcsr_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v1, rdy1, d1, q1, done1, fv1, inv1;
    logic [1:0] sel1, op1;
    logic [4:0] fl1, ff1;
    logic [2:0] frm1;

    logic       v4, rdy4, done4, fv4, inv4;
    logic [1:0] sel4, op4;
    logic [3:0] d4, q4;
    logic [4:0] fl4, ff4;
    logic [2:0] frm4;

`ifdef FCSR_FRM_CHECK_EN
    localparam logic INV_EXP = 1'b1;
`else
    localparam logic INV_EXP = 1'b0;
`endif

    serv_fcsr_ctrl #(.W(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_sel(sel1), .i_req_op(op1), .i_d(d1), .o_q(q1), .o_done(done1),
        .i_flags_valid(fv1), .i_flags(fl1), .o_fflags(ff1), .o_frm(frm1),
        .o_frm_invalid(inv1)
    );

    serv_fcsr_ctrl #(.W(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(v4), .o_req_ready(rdy4),
        .i_req_sel(sel4), .i_req_op(op4), .i_d(d4), .o_q(q4), .o_done(done4),
        .i_flags_valid(fv4), .i_flags(fl4), .o_fflags(ff4), .o_frm(frm4),
        .o_frm_invalid(inv4)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  op;
        logic [31:0] d;
        int          fslice;
        logic [4:0]  fl;
        logic [31:0] exp_q;
        logic [2:0]  exp_frm;
        logic [4:0]  exp_ff;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the o_q stream and the cycle count from accept to o_done (ends in the COMMIT cycle).
    task automatic req1(input logic [1:0] sel, input logic [1:0] op, input logic [31:0] d,
                        input int fslice, input logic [4:0] fl,
                        output logic [31:0] qs, output int lat);
        int n;
        v1 = 1'b1; sel1 = sel; op1 = op; n = 0; qs = '0;
        while (!rdy1 && n < 100) begin step(); n++; end
        step();
        v1 = 1'b0; lat = 1;
        while (!done1 && lat < 60) begin
            if (lat <= 32) begin
                d1 = d[lat-1];
                fv1 = ((lat - 1) == fslice);
                fl1 = fl;
                qs[lat-1] = q1;
            end else begin
                d1 = 1'b0; fv1 = 1'b0;
            end
            step();
            lat++;
        end
        d1 = 1'b0; fv1 = 1'b0;
    endtask

    task automatic req4(input logic [1:0] sel, input logic [1:0] op, input logic [31:0] d,
                        output logic [31:0] qs, output int lat);
        int n;
        v4 = 1'b1; sel4 = sel; op4 = op; n = 0; qs = '0;
        while (!rdy4 && n < 100) begin step(); n++; end
        step();
        v4 = 1'b0; lat = 1;
        while (!done4 && lat < 30) begin
            if (lat <= 8) begin
                d4 = d[(lat-1)*4 +: 4];
                qs[(lat-1)*4 +: 4] = q4;
            end else begin
                d4 = 4'h0;
            end
            step();
            lat++;
        end
        d4 = 4'h0;
    endtask

    initial begin
        logic [31:0] qs;
        int lat, a1, a2, cyc, dcnt;

        tbl[0] = '{2'b11, 2'b01, 32'h000000E3, -1, 5'b00000, 32'h00, 3'b111, 5'b00011};
        tbl[1] = '{2'b01, 2'b01, 32'h00000015, -1, 5'b00000, 32'h03, 3'b111, 5'b10101};
        tbl[2] = '{2'b01, 2'b11, 32'h0000001F, 10, 5'b00010, 32'h15, 3'b111, 5'b00010};
        tbl[3] = '{2'b10, 2'b00, 32'hFFFFFFFF, -1, 5'b00000, 32'h07, 3'b111, 5'b00010};
        tbl[4] = '{2'b00, 2'b01, 32'h000000FF, -1, 5'b00000, 32'h00, 3'b111, 5'b00010};
        tbl[5] = '{2'b11, 2'b10, 32'h0000000C, -1, 5'b00000, 32'hE2, 3'b111, 5'b01110};
        tbl[6] = '{2'b10, 2'b01, 32'h00000012, -1, 5'b00000, 32'h07, 3'b010, 5'b01110};
        tbl[7] = '{2'b11, 2'b11, 32'hFFFFFFFF, -1, 5'b00000, 32'h4E, 3'b000, 5'b00000};
        tbl[8] = '{2'b01, 2'b10, 32'h00000011, 31, 5'b00100, 32'h00, 3'b000, 5'b10101};
        tbl[9] = '{2'b01, 2'b01, 32'hFFFFFFE0, -1, 5'b00000, 32'h15, 3'b000, 5'b00000};

        v1 = 0; sel1 = 0; op1 = 0; d1 = 0; fv1 = 0; fl1 = 0;
        v4 = 0; sel4 = 0; op4 = 0; d4 = 0; fv4 = 0; fl4 = 0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_done",  32'(done1), 32'd0);
        check("rst_q",     32'(q1), 32'd0);
        check("rst_frm",   32'(frm1), 32'd0);
        check("rst_fflags", 32'(ff1), 32'd0);
        check("rst_inv",   32'(inv1), 32'd0);
        check("rst_q4",    32'(q4), 32'd0);

        // W=4: frm set 0x3 over frm=100 with fflags=00001.
        fv4 = 1'b1; fl4 = 5'b00001;
        step();
        fv4 = 1'b0;
        req4(2'b10, 2'b01, 32'h4, qs, lat);
        step();
        check("w4_frm_init", 32'(frm4), 32'h4);
        req4(2'b10, 2'b10, 32'h3, qs, lat);
        check("w4_latency", 32'(lat), 32'd9);
        check("w4_q_stream", qs, 32'h4);
        step();
        check("w4_frm", 32'(frm4), 32'h7);
        check("w4_fflags", 32'(ff4), 32'h1);

        for (int i = 0; i < 10; i++) begin
            req1(tbl[i].sel, tbl[i].op, tbl[i].d, tbl[i].fslice, tbl[i].fl, qs, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d_q_commit", i), 32'(q1), 32'd0);
            check($sformatf("v%0d_q_stream", i), qs, tbl[i].exp_q);
            step();
            check($sformatf("v%0d_frm", i), 32'(frm1), 32'(tbl[i].exp_frm));
            check($sformatf("v%0d_fflags", i), 32'(ff1), 32'(tbl[i].exp_ff));
            check($sformatf("v%0d_ready", i), 32'(rdy1), 32'd1);
        end

        // IDLE strobe lands directly; a strobe on the accept cycle is not in the snapshot.
        fv1 = 1'b1; fl1 = 5'b01000;
        step();
        fv1 = 1'b0;
        check("idle_strobe", 32'(ff1), 32'h08);
        fv1 = 1'b1; fl1 = 5'b00001;
        req1(2'b01, 2'b00, 32'h0, -1, 5'b00000, qs, lat);
        check("accept_strobe_q", qs, 32'h08);
        step();
        check("accept_strobe_ff", 32'(ff1), 32'h09);

        // Reserved-mode detection follows frm with one register stage.
        req1(2'b10, 2'b01, 32'h5, -1, 5'b00000, qs, lat);
        step(); step();
        check("frm_101", 32'(frm1), 32'h5);
        check("inv_101", 32'(inv1), 32'(INV_EXP));
        req1(2'b10, 2'b01, 32'h2, -1, 5'b00000, qs, lat);
        step(); step();
        check("inv_010", 32'(inv1), 32'd0);

        // Valid held through a busy access: next accept is 34 cycles later.
        v1 = 1'b1; sel1 = 2'b01; op1 = 2'b00; d1 = 1'b0;
        a1 = -1; a2 = -1; cyc = 0;
        while (a2 < 0 && cyc < 200) begin
            if (rdy1) begin
                if (a1 < 0) a1 = cyc;
                else a2 = cyc;
            end
            step();
            cyc++;
        end
        v1 = 1'b0;
        check("b2b_spacing", 32'(a2 - a1), 32'd34);

        // Abort the second access with a flag pending.
        fv1 = 1'b1; fl1 = 5'b11111;
        step();
        fv1 = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ready", 32'(rdy1), 32'd1);
        check("abort_frm", 32'(frm1), 32'd0);
        check("abort_fflags", 32'(ff1), 32'd0);
        check("abort_q", 32'(q1), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done1) dcnt++;
            step();
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_fflags_late", 32'(ff1), 32'd0);
        check("abort_inv", 32'(inv1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
